// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: FSM state types and
// E-stage forward-select codes, plus the forward-select priority helper.
package hazard_pkg;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    typedef enum logic {
        EX_IDLE = 1'b0,
        EX_WAIT = 1'b1
    } ex_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    // The M stage holds the younger result, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        logic [1:0] sel;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mdu_tracker.sv
// Tracks an in-flight multi-cycle mult/div: IDLE/BUSY state, busy-cycle
// counter and the one-cycle timeout when the MDU never reports done.
module mdu_tracker
    import hazard_pkg::*;
#(
    parameter int MDU_MAX = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic mdu_start,
    input  logic mdu_done,
    input  logic flush_e,
    input  logic except_m,
    output logic busy,
    output logic timeout
);

    localparam int CW = (MDU_MAX > 2) ? $clog2(MDU_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(MDU_MAX - 1);

    mdu_state_e    state_r;
    logic [CW-1:0] cnt_r;
    logic          busy_s;
    logic          timeout_s;

    assign busy_s    = (state_r == MDU_BUSY);
    assign timeout_s = busy_s & (cnt_r == LAST);
    assign busy      = busy_s;
    assign timeout   = timeout_s;

    // State and busy-cycle counter; the counter shows 0 in the first BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MDU_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                MDU_IDLE: begin
                    cnt_r <= {CW{1'b0}};
                    if (mdu_start & ~mdu_done & ~flush_e & ~except_m) begin
                        state_r <= MDU_BUSY;
                    end else begin
                        state_r <= MDU_IDLE;
                    end
                end
                MDU_BUSY: begin
                    if (except_m | mdu_done | timeout_s) begin
                        state_r <= MDU_IDLE;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        state_r <= MDU_BUSY;
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= MDU_IDLE;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: forwarding, load/branch/MDU stalls, prioritised
// stage stall/flush control, exception fetch-drain FSM and a stall counter.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32,
    parameter int MDU_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jrD,
    input  logic              mfhiloD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              mdu_startE,
    input  logic              mdu_doneE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              is_exceptM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              i_stall,
    input  logic              d_stall,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              mdu_busy,
    output logic              mdu_timeout,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    ex_state_e        ex_state_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [4:0]       stall_s;   // {F, D, E, M, W}
    logic [3:0]       flush_s;   // {D, E, M, W}
    logic             lwstall_s;
    logic             brstall_s;
    logic             mdustall_s;
    logic             ex_wait_s;
    logic             trk_busy_s;
    logic             trk_timeout_s;

    mdu_tracker #(
        .MDU_MAX(MDU_MAX)
    ) u_mdu_tracker (
        .clk      (clk),
        .rst      (rst),
        .mdu_start(mdu_startE),
        .mdu_done (mdu_doneE),
        .flush_e  (flush_s[2]),
        .except_m (is_exceptM),
        .busy     (trk_busy_s),
        .timeout  (trk_timeout_s)
    );

    assign lwstall_s  = memtoregE & ((rtE == rsD) | (rtE == rtD));
    assign brstall_s  = (branchD | jrD) &
                        ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                         (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
    assign mdustall_s = (trk_busy_s & ~mdu_doneE) | (mfhiloD & trk_busy_s) |
                        (~trk_busy_s & mdu_startE & ~mdu_doneE);
    assign ex_wait_s  = (ex_state_r == EX_WAIT);

    // Operand forwarding selects; register 0 is hard-wired and never forwarded.
    always_comb begin
        forwardaD = 1'b0;
        forwardbD = 1'b0;
        forwardaE = FWD_RF;
        forwardbE = FWD_RF;
        if (rst) begin
            forwardaD = 1'b0;
            forwardbD = 1'b0;
        end else begin
            forwardaD = (rsD != REG_ZERO) & regwriteM & (rsD == writeregM);
            forwardbD = (rtD != REG_ZERO) & regwriteM & (rtD == writeregM);
            forwardaE = fwd_sel((rsE != REG_ZERO) & regwriteM & (rsE == writeregM),
                                (rsE != REG_ZERO) & regwriteW & (rsE == writeregW));
            forwardbE = fwd_sel((rtE != REG_ZERO) & regwriteM & (rtE == writeregM),
                                (rtE != REG_ZERO) & regwriteW & (rtE == writeregW));
        end
    end

    // Prioritised stall/flush; while draining a fetch after an exception the
    // D stage keeps being flushed and F follows the I-cache.
    always_comb begin
        stall_s = 5'b00000;
        flush_s = 4'b0000;
        if (rst) begin
            flush_s = 4'b1111;
        end else if (is_exceptM & d_stall) begin
            stall_s = 5'b11111;
        end else if (is_exceptM) begin
            flush_s = 4'b1111;
        end else begin
            if (i_stall | d_stall) begin
                stall_s = 5'b11111;
            end else if (mdustall_s) begin
                stall_s = 5'b11100;
                flush_s = 4'b0010;
            end else if (lwstall_s | brstall_s) begin
                stall_s = 5'b11000;
                flush_s = 4'b0100;
            end else begin
                stall_s = 5'b00000;
                flush_s = 4'b0000;
            end
            stall_s[4] = ex_wait_s ? i_stall : stall_s[4];
            flush_s[3] = ex_wait_s | flush_s[3];
        end
    end

    assign {stallF, stallD, stallE, stallM, stallW} = stall_s;
    assign {flushD, flushE, flushM, flushW}         = flush_s;
    assign mdu_busy    = ~rst & trk_busy_s;
    assign mdu_timeout = ~rst & trk_timeout_s;
    assign stall_cnt   = stall_cnt_r;

    // Exception FSM: wait out an in-flight I-cache miss after an exception.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_state_r <= EX_IDLE;
        end else begin
            case (ex_state_r)
                EX_IDLE: ex_state_r <= (is_exceptM & i_stall & ~d_stall) ? EX_WAIT : EX_IDLE;
                EX_WAIT: ex_state_r <= i_stall ? EX_WAIT : EX_IDLE;
                default: ex_state_r <= EX_IDLE;
            endcase
        end
    end

    // Saturating count of D-stage stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s[3] & (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: doc/hazard_ctrl_mc.md
HAZARD_CTRL_MC -- requirements
Module: hazard_ctrl_mc

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter CNT_W, default 32, stall-counter width.
REQ-003 Parameter MDU_MAX, default 64, maximum cycles the MDU may stay busy before a timeout.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 Port list, one per line (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rsD, rtD  in  REG_AW  D-stage sources
- branchD, jrD, mfhiloD  in  1  D-stage branch, jump-register, and HI/LO-read flags
- rsE, rtE, writeregE  in  REG_AW  E-stage sources and destination
- regwriteE, memtoregE  in  1  E-stage register write and load
- mdu_startE  in  1  multi-cycle mult/div issued in E
- mdu_doneE  in  1  MDU result valid
- writeregM  in  REG_AW  M-stage destination
- regwriteM, memtoregM, is_exceptM  in  1  M-stage write, load, and exception flags
- writeregW  in  REG_AW  W-stage destination
- regwriteW  in  1  W-stage write
- i_stall, d_stall  in  1  instruction-cache and data-cache miss busy
- forwardaD, forwardbD  out  1  D-stage forward from M
- forwardaE, forwardbE  out  2  E-stage forward select: 00 register file, 10 from M, 01 from W
- stallF, stallD, stallE, stallM, stallW  out  1  per-stage hold
- flushD, flushE, flushM, flushW  out  1  per-stage bubble insert
- mdu_busy  out  1  MDU FSM in BUSY
- mdu_timeout  out  1  one-cycle pulse on MDU timeout
- stall_cnt  out  CNT_W  count of cycles with stallD high

Function
REQ-006 Forwarding SHALL be combinational: source register 0 never forwards; M takes priority over W; forwardaD/forwardbD SHALL be high when rsD/rtD equals writeregM and regwriteM is high.
REQ-007 lwstall SHALL be memtoregE & (rtE==rsD | rtE==rtD).
REQ-008 brstall SHALL be (branchD|jrD) & ((regwriteE & writeregE∈{rsD,rtD}) | (memtoregM & writeregM∈{rsD,rtD})).
REQ-009 MDU FSM states SHALL be MDU_IDLE and MDU_BUSY.
REQ-010 MDU FSM transitions:
- IDLE→BUSY when mdu_startE & ~mdu_doneE & ~flushE & ~is_exceptM.
- BUSY→IDLE on mdu_doneE, or on timeout.
- BUSY→IDLE on is_exceptM, which aborts the operation.
REQ-011 A busy counter SHALL clear on entering BUSY and increment each BUSY cycle; reaching MDU_MAX-1 SHALL force IDLE and pulse mdu_timeout for one cycle.
REQ-012 mdustall SHALL be (state==BUSY & ~mdu_doneE) | (mfhiloD & state==BUSY), or mdu_startE & ~mdu_doneE while IDLE.
REQ-013 Exception FSM states SHALL be EX_IDLE and EX_WAIT.
REQ-014 Exception FSM transitions:
- is_exceptM & i_stall & ~d_stall in EX_IDLE → EX_WAIT.
- EX_WAIT → EX_IDLE on the first cycle i_stall is low.
REQ-015 While in EX_WAIT, flushD SHALL be held at 1 so the in-flight fetch is discarded, and stallF SHALL equal i_stall.
REQ-016 Stage control SHALL follow this priority, highest first:
- (a) is_exceptM & d_stall: all stalls 1, all flushes 0, exception deferred.
- (b) is_exceptM: all flushes 1, all stalls 0.
- (c) i_stall|d_stall: all stalls 1, all flushes 0.
- (d) mdustall: stallF, stallD, stallE 1; flushM 1.
- (e) lwstall|brstall: stallF, stallD 1; flushE 1.
- (f) otherwise: all 0.
REQ-017 EX_WAIT behaviour (REQ-015) SHALL override levels (c)–(f).
REQ-018 stall_cnt SHALL increment on every cycle stallD is high and saturate at all-ones (no wrap).

Reset
REQ-019 While rst is high, the outputs SHALL be:
- stalls 0
- flushD, flushE, flushM, flushW 1
- forwards 0
- mdu_busy 0, mdu_timeout 0
REQ-020 On the first cycle after rst falls:
- MDU FSM in IDLE, exception FSM in EX_IDLE
- busy counter 0, stall_cnt 0
REQ-021 Reset asserted mid-MDU or mid-EX_WAIT SHALL return both FSMs to idle on the next edge.

Structure
REQ-022 The FSM state encodings and the forward-select constants (FWD_RF, FWD_M, FWD_W) SHALL live in a shared package, hazard_pkg.
REQ-023 The MDU FSM, busy counter and timeout SHALL be one sub-module, mdu_tracker; forwarding, priority and the exception FSM SHALL stay in the top.

Verification
REQ-024 Load-use: memtoregE=1, rtE=8, rsD=8 → stallF=1, stallD=1, flushE=1 for one cycle; stall_cnt +1.
REQ-025 Double write: rsE=3, writeregM=3, writeregW=3, regwriteM=1, regwriteW=1 → forwardaE=10; with rsE=0 → forwardaE=00.
REQ-026 Divide: mdu_startE pulse, mdu_doneE 10 cycles later → mdu_busy high 10 cycles, flushM high every stalled cycle, stallE drops in the done cycle.
REQ-027 Timeout: MDU_MAX=8, mdu_doneE never asserted → mdu_timeout pulses at the 8th BUSY cycle, FSM returns to IDLE.
REQ-028 Exception during i_stall: is_exceptM=1, i_stall=1 for 3 cycles:
- cycle 0: all flushes 1.
- next 3 cycles: flushD 1, stallF 1.
- cycle i_stall falls: EX_IDLE.
REQ-029 Exception during d_stall: is_exceptM=1, d_stall=1 for 2 cycles → all stalls 1 and no flush for 2 cycles; then a one-cycle flush of all stages.
